nn_weight_loader: RTL
=====================

# nn_weight_loader

Streams signed weights into the FeedForwardNN weight RAM so new networks can be loaded without recompiling the RAM init file. It accepts one weight per handshake, packs weights LSB-first into WORD_LENGTH-bit lines, and writes each full line (or the partial final line) into the RAM. The packing is the layout the FeedForwardNN datapath reads: weight N at bits [(N+1)*WWIDTH-1 : N*WWIDTH]. It sits between the host/config stream and the ram_pos_thru write port, and holds the network idle while a load is in progress.

## Interface
- WWIDTH, 32, bit width of one weight; must divide WORD_LENGTH
- WORD_LENGTH, 1024, RAM line width; SLOTS = WORD_LENGTH/WWIDTH (32 by default)
- ADDR_WIDTH, 4, RAM address width
- CLK  in  1  clock; all logic on posedge
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; ignored unless idle
- base_addr  in  ADDR_WIDTH  first line address; sampled with start
- in_valid  in  1  weight present
- in_ready  out  1  loader accepts weight this cycle
- in_data  in  WWIDTH  weight bits; stored raw, no arithmetic
- in_last  in  1  marks final weight of the load
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_d  out  WORD_LENGTH  RAM write data
- mem_q  in  WORD_LENGTH  RAM read data; used only with readback
- nn_hold  out  1  high while busy; holds the network in reset
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- wrapped  out  1  sticky; address wrapped past 2^ADDR_WIDTH-1 during this load
- err  out  1  sticky readback mismatch; stays 0 when readback is compiled out

## Operation
- States are IDLE, FILL, WRITE, VERIFY, CHECK and DONE.
  - VERIFY and CHECK exist only with readback.
- IDLE:
  - in_ready=0.
  - On start: latch cur_addr=base_addr, clear the line register and slot counter, clear wrapped and err, then go to FILL.
- FILL:
  - in_ready=1.
  - On each accept (in_valid&&in_ready), write in_data to slot[cnt] and increment cnt.
  - If the accepted weight is the last slot (cnt==SLOTS-1) or in_last=1, go to WRITE and latch last_seen=in_last.
- WRITE, one cycle:
  - mem_we=1, mem_addr=cur_addr, mem_d=line, in_ready=0.
  - Slots that were not filled are 0.
  - Next state: VERIFY if readback is compiled in; otherwise DONE if last_seen, else FILL.
  - Before returning to FILL: increment cur_addr modulo 2^ADDR_WIDTH, clear the line and cnt.
  - If cur_addr was all-ones when incremented, set wrapped.
- DONE, one cycle: done=1, then go to IDLE.
- busy and nn_hold are 1 in every state except IDLE.
- Boundary cases:
  - start while busy is ignored.
  - start and in_valid together in IDLE: the start is taken; no data is accepted that cycle.
  - in_last on the last slot produces exactly one write, not an extra empty line.
  - A load of exactly SLOTS weights without in_last writes one line, then waits in FILL for more data.
- RST asserted at any time forces all outputs and state to reset values immediately. A partially filled line is discarded and never written.

## Timing
- Reset values:
  - in_ready, mem_we, busy, nn_hold, done, wrapped and err are 0.
  - mem_addr=0 and mem_d=0.
- All outputs are registered except in_ready, which is decoded from the state register (a pure function of state, with no combinational path from in_valid).
- Write latency: the final accept of a line happens at edge N. mem_we is high from edge N to N+1, and the RAM captures the line at edge N+1.
- Without readback, done is high from N+1 to N+2 after the last line's write, and busy drops at N+2.
- Sustained throughput is SLOTS weights per SLOTS+1 cycles.
  - With readback it is SLOTS+3 cycles, because the extra VERIFY and CHECK cycles each cost one.

## Configuration
- WEIGHT_LOADER_READBACK_EN defined:
  - After WRITE, the VERIFY state holds mem_addr with mem_we=0 for one cycle.
  - CHECK then compares mem_q against the written line and sets err on any difference.
  - CHECK then goes to DONE or FILL under the same rules as WRITE.
- Not defined:
  - There are no VERIFY/CHECK states and mem_q is unused.
  - err is tied to 0.

## Test plan
- WWIDTH=32, start with base_addr=0, 30 weights of values 1..30, in_last on the 30th:
  - Exactly one write to addr 0.
  - mem_d slots 0..29 = 1..30 and slots 30..31 = 0.
  - done pulses once and wrapped=0.
- 40 weights of values 1..40, in_last on the 40th:
  - Write to addr 0 with slots 0..31 = 1..32.
  - Write to addr 1 with slots 0..7 = 33..40 and the rest 0.
  - in_ready=0 during each WRITE cycle, and no weight is lost with in_valid held high.
- base_addr=15, 33 weights:
  - Writes to addr 15, then to addr 0.
  - wrapped=1 after the load, and cleared by the next start.
- Random in_valid gaps, plus start pulsed again mid-load:
  - Line contents are identical to the gapless run.
  - The second start is ignored.
- RST asserted after 10 weights:
  - busy, nn_hold and in_ready drop immediately, and mem_we is never asserted.
  - A fresh load of 5 weights writes them into slots 0..4.
- With WEIGHT_LOADER_READBACK_EN, the bench RAM model returns one flipped bit on the readback of addr 1:
  - err=1 and stays set through done.
  - A clean reload clears err.

Source files
------------

// File: rtl/nn_weight_loader_if.sv
// Stream and RAM-port bundle for nn_weight_loader.
// The master side is the host/RAM environment; the slave side is the loader.
interface nn_weight_loader_if #(
  parameter int unsigned WWIDTH      = 32,
  parameter int unsigned WORD_LENGTH = 1024,
  parameter int unsigned ADDR_WIDTH  = 4
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic [WWIDTH-1:0]      in_data;
  logic                   in_last;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [WORD_LENGTH-1:0] mem_d;
  logic [WORD_LENGTH-1:0] mem_q;
  logic                   nn_hold;
  logic                   busy;
  logic                   done;
  logic                   wrapped;
  logic                   err;

  modport master (
    output start, base_addr, in_valid, in_data, in_last, mem_q,
    input  in_ready, mem_we, mem_addr, mem_d, nn_hold, busy, done, wrapped, err
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, in_last, mem_q,
    output in_ready, mem_we, mem_addr, mem_d, nn_hold, busy, done, wrapped, err
  );
endinterface

// File: rtl/nn_weight_loader.sv
// Packs streamed weights LSB-first into RAM lines for the FeedForwardNN weight RAM.
// Define WEIGHT_LOADER_READBACK_EN to add a read-back verify of every written line.
module nn_weight_loader #(
  parameter int unsigned WWIDTH      = 32,
  parameter int unsigned WORD_LENGTH = 1024,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input logic               clk,
  input logic               rst,
  nn_weight_loader_if.slave bus
);
  localparam int unsigned Slots    = WORD_LENGTH / WWIDTH;
  localparam int unsigned CntWidth = (Slots > 1) ? $clog2(Slots) : 1;
  localparam logic [CntWidth-1:0] LastSlot = CntWidth'(Slots - 1);

`ifdef WEIGHT_LOADER_READBACK_EN
  typedef enum logic [2:0] {StIdle, StFill, StWrite, StVerify, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;
`endif

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] line_q, line_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   last_q, last_d;
  logic                   wrapped_q, wrapped_d;
  logic                   we_q, busy_q, done_q;
  logic                   line_done;
`ifdef WEIGHT_LOADER_READBACK_EN
  logic                   err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    last_d    = last_q;
    wrapped_d = wrapped_q;
`ifdef WEIGHT_LOADER_READBACK_EN
    err_d     = err_q;
`endif
    line_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d    = bus.base_addr;
          line_d    = '0;
          cnt_d     = '0;
          wrapped_d = 1'b0;
`ifdef WEIGHT_LOADER_READBACK_EN
          err_d     = 1'b0;
`endif
          state_d   = StFill;
        end
      end
      StFill: begin
        if (bus.in_valid) begin
          line_d[cnt_q*WWIDTH +: WWIDTH] = bus.in_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastSlot || bus.in_last) begin
            last_d  = bus.in_last;
            state_d = StWrite;
          end
        end
      end
`ifdef WEIGHT_LOADER_READBACK_EN
      StWrite:  state_d = StVerify;
      StVerify: state_d = StCheck;
      StCheck: begin
        if (bus.mem_q != line_q) err_d = 1'b1;
        line_done = 1'b1;
      end
`else
      StWrite:  line_done = 1'b1;
`endif
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A line has left the loader: finish the load or open the next line.
    if (line_done) begin
      if (last_q) begin
        state_d = StDone;
      end else begin
        state_d = StFill;
        addr_d  = addr_q + 1'b1;
        line_d  = '0;
        cnt_d   = '0;
        if (&addr_q) wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      line_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      wrapped_q <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WEIGHT_LOADER_READBACK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      wrapped_q <= wrapped_d;
      we_q      <= (state_d == StWrite);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
`ifdef WEIGHT_LOADER_READBACK_EN
      err_q     <= err_d;
`endif
    end
  end

  // in_ready depends on state only, so upstream never sees a valid->ready path.
  assign bus.in_ready = (state_q == StFill);
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_d    = line_q;
  assign bus.busy     = busy_q;
  assign bus.nn_hold  = busy_q;
  assign bus.done     = done_q;
  assign bus.wrapped  = wrapped_q;

`ifdef WEIGHT_LOADER_READBACK_EN
  assign bus.err = err_q;
`else
  logic unused_mem_q;
  assign unused_mem_q = ^bus.mem_q;
  assign bus.err      = 1'b0;
`endif
endmodule
